// File: rtl/adc_acq_sequencer.sv
// adc_acq_sequencer
// -----------------------------------------------------------------------------
// Sequences one 12-bit parallel ADC capture path. A programmable divider
// produces the sample tick; each tick pulses the ADC convert strobe, waits
// for the ADC busy line to fall and then strobes the parallel load register.
// Every captured word is flagged downstream with a valid/ready handshake.
// Acquisition runs either continuously or for a burst of N samples.
//
// Ports
//   ck         system clock, all logic on the rising edge
//   rst        synchronous active-high reset, overrides every other input
//   en         acquisition enable (level); a 0->1 edge in IDLE starts a run
//   div        sample period minus one in ck cycles, latched at start
//   n_samples  burst length, 0 selects continuous mode, latched at start
//   adc_busy   ADC conversion in progress, synchronous to ck
//   adc_conv   ADC convert-start strobe, high for CONV_CYC cycles
//   ld         one-cycle load strobe to the parallel capture register
//   out_valid  captured word available downstream
//   out_ready  downstream accepts the word
//   done       one-cycle pulse when a burst completes
//   overrun    sticky, a sample tick was missed
//   err        sticky, the ADC busy line timed out
//   busy       high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module adc_acq_sequencer #(
  parameter int DIV_W    = 16,
  parameter int CNT_W    = 16,
  parameter int CONV_CYC = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             adc_busy,
  output logic             adc_conv,
  output logic             ld,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done,
  output logic             overrun,
  output logic             err,
  output logic             busy
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int CC_W = $clog2(CONV_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_CONV,
    S_WAIT_BUSY,
    S_LOAD
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic             r_enQ;
  logic [DIV_W-1:0] r_divLat;
  logic [CNT_W-1:0] r_nLat;
  logic [DIV_W-1:0] r_tickCnt;
  logic [CNT_W-1:0] r_sampCnt;
  logic [TO_W-1:0]  r_toCnt;
  logic [CC_W-1:0]  r_convCnt;
  logic             r_outValid;
  logic             r_done;
  logic             r_overrun;
  logic             r_err;

  logic             w_enRise;
  logic             w_tick;
  logic [CNT_W-1:0] w_cntInc;
  logic             w_start;
  logic             w_stall;
  logic             w_timeout;
  logic             w_loadCommit;
  logic             w_burstEnd;
  logic             w_lateTick;

  // The tick fires on the wrap cycle of the period counter, so one period
  // spans div+1 cycles and div=0 ticks every cycle. No ticks while idle.
  assign w_enRise  = en & ~r_enQ;
  assign w_tick    = (r_state != S_IDLE) && (r_tickCnt == r_divLat);
  assign w_cntInc  = r_sampCnt + CNT_W'(1);

  // A tick landing while a conversion is still being handled is dropped
  // rather than queued; it only leaves a mark in the overrun flag.
  assign w_lateTick = w_tick && ((r_state == S_CONV) ||
                                 (r_state == S_WAIT_BUSY) ||
                                 (r_state == S_LOAD));

  // Strobes are decoded straight from the state register so that leaving a
  // state (abort or reset) drops them on that very edge.
  assign adc_conv  = (r_state == S_CONV);
  assign ld        = (r_state == S_LOAD);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_outValid;
  assign done      = r_done;
  assign overrun   = r_overrun;
  assign err       = r_err;

  // State register. Reset wins over everything, including a conversion
  // that is in flight.
  always_ff @(posedge ck) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic plus the one-cycle event qualifiers used by the
  // datapath. Dropping en abandons whatever is going on and returns to
  // IDLE without finishing the sample. A stalled downstream at tick time
  // means the sample is skipped, which is what keeps ld from ever
  // overwriting a word that has not been accepted yet.
  always_comb begin
    w_stateNext  = r_state;
    w_start      = 1'b0;
    w_stall      = 1'b0;
    w_timeout    = 1'b0;
    w_loadCommit = 1'b0;
    w_burstEnd   = 1'b0;
    if (!en) begin
      w_stateNext = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_enRise) begin
            w_start     = 1'b1;
            w_stateNext = S_WAIT_TICK;
          end
        end
        S_WAIT_TICK: begin
          if (w_tick) begin
            if (r_outValid && !out_ready) begin
              w_stall = 1'b1;
            end else begin
              w_stateNext = S_CONV;
            end
          end
        end
        S_CONV: begin
          if (r_convCnt == CC_W'(CONV_CYC - 1)) begin
            w_stateNext = S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (!adc_busy) begin
            w_stateNext = S_LOAD;
          end else if (r_toCnt == TO_W'(TIMEOUT - 1)) begin
            w_timeout   = 1'b1;
            w_stateNext = S_WAIT_TICK;
          end
        end
        S_LOAD: begin
          w_loadCommit = 1'b1;
          if ((r_nLat != '0) && (w_cntInc == r_nLat)) begin
            w_burstEnd  = 1'b1;
            w_stateNext = S_IDLE;
          end else begin
            w_stateNext = S_WAIT_TICK;
          end
        end
        default: begin
          w_stateNext = S_IDLE;
        end
      endcase
    end
  end

  // Datapath: enable history, latched run parameters, period/burst/
  // conversion/timeout counters and the status flags. The enable history
  // keeps following en during reset so that holding en high across a reset
  // does not look like a fresh 0->1 edge afterwards.
  always_ff @(posedge ck) begin
    r_enQ <= en;
    if (rst) begin
      r_divLat   <= '0;
      r_nLat     <= '0;
      r_tickCnt  <= '0;
      r_sampCnt  <= '0;
      r_toCnt    <= '0;
      r_convCnt  <= '0;
      r_outValid <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_start) begin
        r_divLat  <= div;
        r_nLat    <= n_samples;
        r_sampCnt <= '0;
      end else if (w_loadCommit) begin
        r_sampCnt <= w_cntInc;
      end

      if ((r_state == S_IDLE) || w_tick) begin
        r_tickCnt <= '0;
      end else begin
        r_tickCnt <= r_tickCnt + DIV_W'(1);
      end

      if ((r_state == S_CONV) && (w_stateNext == S_CONV)) begin
        r_convCnt <= r_convCnt + CC_W'(1);
      end else begin
        r_convCnt <= '0;
      end

      if ((r_state == S_WAIT_BUSY) && (w_stateNext == S_WAIT_BUSY)) begin
        r_toCnt <= r_toCnt + TO_W'(1);
      end else begin
        r_toCnt <= '0;
      end

      if (w_start) begin
        r_outValid <= 1'b0;
      end else if (w_loadCommit) begin
        r_outValid <= 1'b1;
      end else if (out_ready) begin
        r_outValid <= 1'b0;
      end

      r_done <= w_burstEnd;

      if (w_start) begin
        r_overrun <= 1'b0;
      end else if (w_stall || (en && w_lateTick)) begin
        r_overrun <= 1'b1;
      end

      if (w_start) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
